mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 256 x 16-bit program/data memory between two requesters: port 0 (instruction fetch, driven by the program counter) and port 1 (data load/store, driven by the execute stage).
- Grants one request at a time using round-robin, sequences a fixed-latency memory access, and returns read data with a one-cycle ack pulse.
- Sits between the core's fetch/execute logic and the memory array.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 16, memory word width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset: asserted (0) resets the block at the next rising clk edge.
- req0  in  1  port 0 request; held high until ack0.
- addr0  in  ADDR_W  port 0 address; stable while req0 is high.
- req1  in  1  port 1 request; held high until ack1.
- we1  in  1  port 1 write enable; 1 = store, 0 = load.
- addr1  in  ADDR_W  port 1 address.
- wdata1  in  DATA_W  port 1 write data.
- ack0  out  1  one-cycle pulse; port 0 transaction complete, rdata valid.
- ack1  out  1  one-cycle pulse; port 1 transaction complete, rdata valid on loads.
- rdata  out  DATA_W  read data; valid only in an ack cycle.
- mem_en  out  1  one-cycle memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after mem_en.
- busy  out  1  high while a transaction is in flight (not IDLE).

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
  - last_grant goes to 1, so port 0 wins the first contention.
- Reset mid-transaction abandons the transaction: no ack is issued, and a pending memory write is not retried.
- States and transitions:
  - IDLE -> ISSUE when req0 or req1 is high.
  - ISSUE -> WAIT, always after one cycle.
  - WAIT -> RESP when the latency counter reaches 0.
  - RESP -> IDLE, always after one cycle.
- IDLE:
  - If only one req is high, grant that port.
  - If both are high, grant the port != last_grant.
  - On a grant: latch the granted port's address, we and wdata into internal registers, update last_grant, and go to ISSUE.
  - Port 0 is always a read (mem_we=0).
- ISSUE:
  - mem_en=1 for exactly one cycle.
  - mem_we, mem_addr and mem_wdata are driven from the latched values.
  - Latency counter loads MEM_LAT-1.
- WAIT:
  - mem_en=0.
  - Counter decrements each cycle.
  - When the counter is 0 in WAIT, capture mem_rdata into rdata on that edge and go to RESP.
- RESP:
  - ack of the granted port = 1 for exactly one cycle; rdata holds the captured value.
  - rdata on a store is don't-care but must not be X; drive captured mem_rdata.
  - Next state is IDLE.
- Latency:
  - req sampled high in IDLE at edge N gives mem_en high during cycle N+1 and ack high during cycle N+2+MEM_LAT.
  - MEM_LAT=1: request-to-ack is 3 cycles.
  - Throughput is one transaction per MEM_LAT+3 cycles.
- Handshake rules:
  - Requesters keep req, addr, we and wdata stable until the ack cycle inclusive.
  - req still high in the cycle after ack is treated as a new request.
  - Latched values make the arbiter immune to input changes after the grant.
  - A req dropped before ack still completes the transaction and still pulses ack.
- Fairness: under continuous contention, grants alternate 0,1,0,1.
- busy = (state != IDLE); it is registered and reflects the state.
- ack0 and ack1 are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, the block adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each) and conflict_cnt (16 bits).
  - gnt_cnt0 / gnt_cnt1 count grants to port 0 / port 1.
  - conflict_cnt counts IDLE cycles where both reqs are high.
  - All three reset to 0 and saturate at 16'hFFFF.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req0=req1=1 -> all outputs 0, no mem_en; first grant after release goes to port 0.
- Single read: MEM_LAT=1, req0=1, addr0=8'h05, memory holds 16'h1234 at 5 -> mem_en with mem_addr=5 one cycle after sampling; ack0 with rdata=16'h1234 exactly 3 cycles after req sampled.
- Store: req1=1, we1=1, addr1=8'h10, wdata1=16'hBEEF -> one mem_en cycle with mem_we=1, mem_addr=8'h10, mem_wdata=16'hBEEF; ack1 pulses once; a subsequent port 0 read of 8'h10 returns 16'hBEEF.
- Contention: req0 and req1 held high for 4 transactions -> ack order 0,1,0,1; never both acks in one cycle; busy low for exactly one cycle between transactions.
- Latency sweep: MEM_LAT=3, read of 8'hFF (top address) -> ack 5 cycles after request sampled, correct data.
- Mid-operation reset: rst=0 during WAIT -> no ack0/ack1 issued; state is IDLE, and a new request completes normally afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter in front of a fixed-latency single-port memory.
// Define MEM_ARB_STATS_EN to add saturating grant and conflict counters.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t     state;
  logic       last_grant;
  logic       gnt;
  logic       pick;
  logic [2:0] cnt;
  // pick = 1 selects port 1; on contention the port that did not win last time goes first
  always_comb pick = (req0 & req1) ? ~last_grant : req1;
  // mem_addr/mem_we/mem_wdata double as the latched request, so later input changes are ignored
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      cnt        <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          state      <= ISSUE;
          busy       <= 1'b1;
          mem_en     <= 1'b1;
          gnt        <= pick;
          last_grant <= pick;
          mem_we     <= pick & we1;
          mem_addr   <= pick ? addr1 : addr0;
          mem_wdata  <= pick ? wdata1 : '0;
        end
        ISSUE: begin
          state  <= WAIT;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= 3'(MEM_LAT - 1);
        end
        WAIT: if (cnt == 3'd0) begin
          state <= RESP;
          rdata <= mem_rdata;
          ack0  <= ~gnt;
          ack1  <= gnt;
        end else cnt <= cnt - 3'd1;
        default: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else if (state == IDLE) begin
      if (req0 & req1 & ~&conflict_cnt) conflict_cnt <= conflict_cnt + 16'd1;
      if (req0 & ~pick & ~&gnt_cnt0) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (pick & ~&gnt_cnt1) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and random traffic against a transaction-level model.
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic req0 = 0, req1 = 0, we1 = 0;
  logic [7:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata1 = '0;
  logic ack0, ack1, mem_en, mem_we, busy;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [7:0] mem_addr;
  logic req0_b = 0, req1_b = 0, we1_b = 0;
  logic [7:0] addr0_b = '0, addr1_b = '0;
  logic [15:0] wdata1_b = '0;
  logic ack0_b, ack1_b, mem_en_b, mem_we_b, busy_b;
  logic [15:0] rdata_b, mem_wdata_b, mem_rdata_b;
  logic [7:0] mem_addr_b;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .req1(req1), .we1(we1), .addr1(addr1),
    .wdata1(wdata1), .ack0(ack0), .ack1(ack1), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req0(req0_b), .addr0(addr0_b), .req1(req1_b), .we1(we1_b), .addr1(addr1_b),
    .wdata1(wdata1_b), .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b));

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h05) ? 16'h1234 : {a, ~a};
  endfunction

  // Memories: unwritten words read as init_val; read data appears MEM_LAT cycles after mem_en
  logic [15:0] mem_a [256];
  bit wr_a [256];
  logic [15:0] rd_a = '0;
  assign mem_rdata = rd_a;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin mem_a[mem_addr] <= mem_wdata; wr_a[mem_addr] <= 1'b1; end
    rd_a <= mem_en ? (wr_a[mem_addr] ? mem_a[mem_addr] : init_val(mem_addr)) : 16'h0;
  end
  logic [15:0] mem_b [256];
  bit wr_b [256];
  logic [15:0] pb0 = '0, pb1 = '0, pb2 = '0;
  assign mem_rdata_b = pb2;
  always @(posedge clk) begin
    if (mem_en_b && mem_we_b) begin mem_b[mem_addr_b] <= mem_wdata_b; wr_b[mem_addr_b] <= 1'b1; end
    pb0 <= mem_en_b ? (wr_b[mem_addr_b] ? mem_b[mem_addr_b] : init_val(mem_addr_b)) : 16'h0;
    pb1 <= pb0;
    pb2 <= pb1;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Transaction-level reference for the MEM_LAT=1 instance
  localparam int LAT = 1;
  logic [15:0] ref_mem [256];
  int cyc = 0, m_g = -100, m_free = 0;
  bit m_act = 0, m_port = 0, m_we = 0, m_last = 1;
  logic [7:0] m_addr = '0;
  logic [15:0] m_wdata = '0, m_rdata = '0;

  task automatic step();
    bit r0 = req0, r1 = req1, w1 = we1, rs = rst;
    logic [7:0] a0 = addr0, a1 = addr1;
    logic [15:0] d1 = wdata1;
    bit e_en, e_busy, e_ack;
    @(posedge clk);
    cyc++;
    if (!rs) begin
      m_act = 0; m_last = 1; m_free = cyc + 1;
    end else if (cyc >= m_free && (r0 || r1)) begin
      m_port = (r0 && r1) ? !m_last : r1;
      m_last = m_port; m_g = cyc; m_act = 1;
      m_we = m_port && w1;
      m_addr = m_port ? a1 : a0;
      m_wdata = d1;
      m_rdata = ref_mem[m_addr];
      if (m_we) ref_mem[m_addr] = d1;
      m_free = cyc + LAT + 3;
    end
    #1;
    e_en = m_act && cyc == m_g;
    e_busy = m_act && cyc >= m_g && cyc < m_g + LAT + 2;
    e_ack = m_act && cyc == m_g + LAT + 1;
    chk("ack0", ack0, e_ack && !m_port);
    chk("ack1", ack1, e_ack && m_port);
    chk("busy", busy, e_busy);
    chk("mem_en", mem_en, e_en);
    if (e_en) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_ack && !m_we) chk("rdata", rdata, m_rdata);
  endtask

  task automatic run_until_ack(input int lim, output int k, output bit p, output logic [15:0] d);
    k = 0; p = 0; d = '0;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (ack0 | ack1) begin k = i; p = ack1; d = rdata; break; end
    end
  endtask

  typedef struct {
    bit r0, r1, w1;
    logic [7:0] a0, a1;
    logic [15:0] d1;
    bit port;
    logic [15:0] rd;
  } vec_t;

  initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    vec_t tbl [6];
    int k, got, lat, en_k;
    bit p, gp, cap_we;
    bit act [2], rel [2];
    logic [7:0] cap_addr;
    logic [15:0] d, grd, cap_wd;
    logic [3:0] order;
    int nack, idle_cnt;
    tbl[0] = '{1, 0, 0, 8'h05, 8'h00, 16'h0000, 0, 16'h1234};
    tbl[1] = '{0, 1, 1, 8'h00, 8'h10, 16'hBEEF, 1, 16'h0000};
    tbl[2] = '{1, 0, 0, 8'h10, 8'h00, 16'h0000, 0, 16'hBEEF};
    tbl[3] = '{0, 1, 0, 8'h00, 8'hFF, 16'h0000, 1, 16'hFF00};
    tbl[4] = '{1, 0, 0, 8'h00, 8'h00, 16'h0000, 0, 16'h00FF};
    tbl[5] = '{0, 1, 0, 8'h00, 8'h05, 16'h0000, 1, 16'h1234};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

    // Reset held with both requests high, then port 0 must win first
    rst = 0; req0 = 1; req1 = 1; addr0 = 8'h33; addr1 = 8'h44;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_outputs", {ack0, ack1, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata}, 64'h0);
    end
    rst = 1;
    step();
    chk("first_grant_en", mem_en, 1'b1);
    chk("first_grant_addr", mem_addr, 8'h33);
    run_until_ack(10, k, p, d);
    chk("first_grant_lat", k, 2); chk("first_grant_port", p, 1'b0); chk("first_grant_data", d, 16'h33CC);
    step(); req0 = 0;
    run_until_ack(10, k, p, d);
    chk("second_grant_lat", k, 3); chk("second_grant_port", p, 1'b1); chk("second_grant_data", d, 16'h44BB);
    step(); req1 = 0; step();

    // Single-requester vectors from IDLE
    for (int i = 0; i < 6; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; we1 = tbl[i].w1;
      addr0 = tbl[i].a0; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      got = 0; lat = 0; en_k = 0; gp = 0; grd = '0; cap_we = 0; cap_addr = '0; cap_wd = '0;
      for (int j = 1; j <= 10 && got == 0; j++) begin
        step();
        if (mem_en) begin en_k = j; cap_we = mem_we; cap_addr = mem_addr; cap_wd = mem_wdata; end
        if (ack0 | ack1) begin got = 1; lat = j; gp = ack1; grd = rdata; end
      end
      chk($sformatf("vec%0d_ack", i), got, 1);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_en_cycle", i), en_k, 1);
      chk($sformatf("vec%0d_port", i), gp, tbl[i].port);
      chk($sformatf("vec%0d_addr", i), cap_addr, tbl[i].port ? tbl[i].a1 : tbl[i].a0);
      chk($sformatf("vec%0d_we", i), cap_we, tbl[i].port && tbl[i].w1);
      if (tbl[i].port && tbl[i].w1) chk($sformatf("vec%0d_wdata", i), cap_wd, tbl[i].d1);
      else chk($sformatf("vec%0d_rdata", i), grd, tbl[i].rd);
      step();
      req0 = 0; req1 = 0; we1 = 0;
      step();
    end

    // Continuous contention: grants alternate starting with port 0
    req0 = 1; req1 = 1; we1 = 0; addr0 = 8'h21; addr1 = 8'h22;
    order = '0; nack = 0; idle_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if ((ack0 | ack1) && nack < 4) begin order[nack] = ack1; nack++; end
      if (!busy) idle_cnt++;
    end
    req0 = 0; req1 = 0;
    chk("contention_acks", nack, 4);
    chk("contention_order", order, 4'b1010);
    chk("contention_idle_cycles", idle_cnt, 4);
    step(); step();

    // Reset during WAIT abandons the read
    req0 = 1; addr0 = 8'h05;
    step(); step();
    rst = 0; req0 = 0;
    step();
    chk("midreset_acks", {ack0, ack1}, 2'b00);
    chk("midreset_busy", busy, 1'b0);
    rst = 1;
    for (int i = 0; i < 3; i++) begin step(); chk("midreset_quiet", {ack0, ack1}, 2'b00); end
    req0 = 1; addr0 = 8'h05;
    run_until_ack(10, k, p, d);
    chk("post_reset_lat", k, 3); chk("post_reset_port", p, 1'b0); chk("post_reset_data", d, 16'h1234);
    step(); req0 = 0; step();

    // Request dropped and address changed right after grant still completes
    req0 = 1; addr0 = 8'h10;
    step();
    req0 = 0; addr0 = 8'h00;
    run_until_ack(10, k, p, d);
    chk("dropped_req_lat", k, 2); chk("dropped_req_port", p, 1'b0); chk("dropped_req_data", d, 16'hBEEF);
    step(); step();

    // MEM_LAT=3 instance, top address
    req0_b = 1; addr0_b = 8'hFF; k = 0; d = '0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (ack0_b) begin k = i; d = rdata_b; break; end
    end
    chk("lat3_cycles", k, 5);
    chk("lat3_rdata", d, 16'hFF00);
    step(); req0_b = 0; step(); step();

    // Random traffic; each port holds its request through its ack cycle
    act[0] = 0; act[1] = 0; rel[0] = 0; rel[1] = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int q = 0; q < 2; q++) if (rel[q]) begin rel[q] = 0; act[q] = 0; end
      if (ack0) rel[0] = 1;
      if (ack1) rel[1] = 1;
      if (!act[0] && $urandom_range(0, 2) == 0) begin act[0] = 1; addr0 = 8'($urandom); end
      if (!act[1] && $urandom_range(0, 2) == 0) begin
        act[1] = 1; addr1 = 8'($urandom); we1 = 1'($urandom); wdata1 = 16'($urandom);
      end
      req0 = act[0]; req1 = act[1];
    end
    req0 = 0; req1 = 0;
    for (int i = 0; i < 8; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
